mem_stage: RTL and testbench

Memory-access pipeline stage of the five-stage core. It latches the EX results into an EX/MEM register and maps 32-bit byte addresses onto the 256 x 8-bit, word-indexed data memory. It drives that memory's address, active-low write enable and write data, and zero-extends load data into the MEM/WB register for writeback. It also detects misaligned and out-of-range accesses, records the first fault, and counts committed stores.

---
 rtl/mem_stage.sv | 116 +++++++++++
 tb/tb_mem_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM and MEM/WB registers, data-memory drive,
// access fault capture and committed-store counting.
module mem_stage #(
  parameter int DW = 32,
  parameter int AW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_alu,
  input  logic [DW-1:0] ex_store_data,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic          ex_reg_write,
  input  logic [4:0]    ex_rd,
  input  logic          stall,
  input  logic          flush,
  output logic [AW-1:0] dm_address,
  output logic          dm_wren,
  output logic [7:0]    dm_w_data,
  input  logic [7:0]    dm_r_data,
  output logic          wb_valid,
  output logic          wb_reg_write,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          fault,
  output logic [DW-1:0] fault_addr,
  output logic [CW-1:0] store_count
);

  logic          m_valid;
  logic [DW-1:0] m_alu;
  logic [7:0]    m_sd;
  logic [4:0]    m_rd;
  logic          m_rd_en;
  logic          m_wr_en;
  logic          m_reg_write;
  logic          m_acc;
  logic          m_bad;
  logic          store_commit;
  logic          unused_sd;

  // memory is byte-wide, so the upper store operand bits never leave this stage
  assign unused_sd = ^ex_store_data[DW-1:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid     <= 1'b0;
      m_alu       <= '0;
      m_sd        <= '0;
      m_rd        <= '0;
      m_rd_en     <= 1'b0;
      m_wr_en     <= 1'b0;
      m_reg_write <= 1'b0;
    end else begin
      if (!stall) begin
        m_alu       <= ex_alu;
        m_sd        <= ex_store_data[7:0];
        m_rd        <= ex_rd;
        m_rd_en     <= ex_mem_read;
        m_wr_en     <= ex_mem_write;
        m_reg_write <= ex_reg_write;
      end
      if (flush)
        m_valid <= 1'b0;
      else if (!stall)
        m_valid <= ex_valid;
    end
  end

  assign dm_address = m_alu[AW+1:2];
  assign dm_w_data  = m_sd;

  // anything beyond the 1 KiB window, unaligned, or both read and write is rejected
  assign m_acc        = m_valid & (m_rd_en | m_wr_en);
  assign m_bad        = m_acc & ((m_alu[1:0] != 2'b00) | (m_alu[DW-1:AW+2] != '0) |
                                 (m_rd_en & m_wr_en));
  assign store_commit = m_valid & m_wr_en & ~m_bad & ~stall & ~flush;
  assign dm_wren      = ~store_commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else if (stall) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
    end else begin
      wb_valid     <= m_valid & ~m_bad & ~flush;
      wb_reg_write <= m_reg_write & m_valid & ~m_bad & ~flush;
      wb_rd        <= m_rd;
      wb_data      <= m_rd_en ? {{(DW-8){1'b0}}, dm_r_data} : m_alu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else if (m_bad && !stall && !flush && !fault) begin
      fault      <= 1'b1;
      fault_addr <= m_alu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      store_count <= '0;
    else if (store_commit)
      store_count <= store_count + 1'b1;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, multi-cycle corner sequences and a
// randomized run against an instruction-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu;
  logic [31:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        flush;
  logic [7:0]  dm_address;
  logic        dm_wren;
  logic [7:0]  dm_w_data;
  logic [7:0]  dm_r_data;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;
  logic [31:0] fault_addr;
  logic [15:0] store_count;

  int vectors = 0;
  int miscompares = 0;

  mem_stage #(.DW(32), .AW(8), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu(ex_alu),
    .ex_store_data(ex_store_data), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .stall(stall), .flush(flush), .dm_address(dm_address), .dm_wren(dm_wren),
    .dm_w_data(dm_w_data), .dm_r_data(dm_r_data), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .fault(fault), .fault_addr(fault_addr), .store_count(store_count)
  );

  always #5 clk = ~clk;

  // data memory the stage talks to: async read, write on the edge when wren is low
  logic [7:0] env_mem [256] = '{default: 8'h00};
  logic       clr_mem = 1'b0;
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= 8'h00;
    end else if (!dm_wren) begin
      env_mem[dm_address] <= dm_w_data;
    end
  end
  assign dm_r_data = env_mem[dm_address];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic rd_en, input logic wr_en, input logic rw,
                       input logic [4:0] rd, input logic st, input logic fl);
    ex_valid = v; ex_alu = alu; ex_store_data = sd; ex_mem_read = rd_en;
    ex_mem_write = wr_en; ex_reg_write = rw; ex_rd = rd; stall = st; flush = fl;
  endtask

  task automatic bubble(input logic st, input logic fl);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, st, fl);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bubble(1'b0, 1'b0);
    rst_n = 1'b0;
    clr_mem = 1'b1;
    step();
    clr_mem = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " dm_address"},   {24'h0, dm_address}, 32'h0);
    chk({tag, " dm_wren"},      {31'h0, dm_wren}, 32'h1);
    chk({tag, " dm_w_data"},    {24'h0, dm_w_data}, 32'h0);
    chk({tag, " wb_valid"},     {31'h0, wb_valid}, 32'h0);
    chk({tag, " wb_reg_write"}, {31'h0, wb_reg_write}, 32'h0);
    chk({tag, " wb_rd"},        {27'h0, wb_rd}, 32'h0);
    chk({tag, " wb_data"},      wb_data, 32'h0);
    chk({tag, " fault"},        {31'h0, fault}, 32'h0);
    chk({tag, " fault_addr"},   fault_addr, 32'h0);
    chk({tag, " store_count"},  {16'h0, store_count}, 32'h0);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic [31:0] sd;
    logic        rd_en;
    logic        wr_en;
    logic        rw;
    logic [4:0]  rd;
    logic [7:0]  e_addr;
    logic        e_wren;
    logic [7:0]  e_wdata;
    logic        e_wbv;
    logic        e_wbrw;
    logic [4:0]  e_wbrd;
    logic [31:0] e_wbdata;
    logic        e_fault;
    logic [31:0] e_faddr;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic [31:0] sd;
    logic        rd_en;
    logic        wr_en;
    logic        rw;
    logic [4:0]  rd;
  } ins_t;

  initial begin
    vec_t tbl[10];
    logic [15:0] base;

    tbl[0] = '{1'b1, 32'h214, 32'h315, 1'b0, 1'b1, 1'b0, 5'd0,
               8'h85, 1'b0, 8'h15, 1'b1, 1'b0, 5'd0, 32'h214, 1'b0, 32'h0, 16'd1};
    tbl[1] = '{1'b1, 32'h214, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5,
               8'h85, 1'b1, 8'h00, 1'b1, 1'b1, 5'd5, 32'h15, 1'b0, 32'h0, 16'd1};
    tbl[2] = '{1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7,
               8'hBB, 1'b1, 8'h00, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 32'h0, 16'd1};
    tbl[3] = '{1'b1, 32'h3FC, 32'hFFFFFFAB, 1'b0, 1'b1, 1'b0, 5'd3,
               8'hFF, 1'b0, 8'hAB, 1'b1, 1'b0, 5'd3, 32'h3FC, 1'b0, 32'h0, 16'd2};
    tbl[4] = '{1'b1, 32'h3FC, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9,
               8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, 5'd9, 32'hAB, 1'b0, 32'h0, 16'd2};
    tbl[5] = '{1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd1,
               8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 5'd1, 32'h0, 1'b0, 32'h0, 16'd2};
    tbl[6] = '{1'b1, 32'h242, 32'h77, 1'b0, 1'b1, 1'b0, 5'd2,
               8'h90, 1'b1, 8'h77, 1'b0, 1'b0, 5'd2, 32'h242, 1'b1, 32'h242, 16'd2};
    tbl[7] = '{1'b1, 32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 5'd4,
               8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 5'd4, 32'h0, 1'b1, 32'h242, 16'd2};
    tbl[8] = '{1'b1, 32'h8, 32'h11, 1'b1, 1'b1, 1'b1, 5'd6,
               8'h02, 1'b1, 8'h11, 1'b0, 1'b0, 5'd6, 32'h0, 1'b1, 32'h242, 16'd2};
    tbl[9] = '{1'b0, 32'h10, 32'h55, 1'b0, 1'b1, 1'b0, 5'd0,
               8'h04, 1'b1, 8'h55, 1'b0, 1'b0, 5'd0, 32'h10, 1'b1, 32'h242, 16'd2};

    rst_n = 1'b0;
    bubble(1'b0, 1'b0);
    repeat (2) step();
    chk_reset_state("reset");
    rst_n = 1'b1;

    // directed vector table, one isolated instruction per entry
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].alu, tbl[i].sd, tbl[i].rd_en, tbl[i].wr_en, tbl[i].rw,
            tbl[i].rd, 1'b0, 1'b0);
      step();
      bubble(1'b0, 1'b0);
      #1;
      chk($sformatf("tbl%0d dm_address", i), {24'h0, dm_address}, {24'h0, tbl[i].e_addr});
      chk($sformatf("tbl%0d dm_wren", i), {31'h0, dm_wren}, {31'h0, tbl[i].e_wren});
      chk($sformatf("tbl%0d dm_w_data", i), {24'h0, dm_w_data}, {24'h0, tbl[i].e_wdata});
      step();
      chk($sformatf("tbl%0d wb_valid", i), {31'h0, wb_valid}, {31'h0, tbl[i].e_wbv});
      chk($sformatf("tbl%0d wb_reg_write", i), {31'h0, wb_reg_write}, {31'h0, tbl[i].e_wbrw});
      chk($sformatf("tbl%0d wb_rd", i), {27'h0, wb_rd}, {27'h0, tbl[i].e_wbrd});
      chk($sformatf("tbl%0d wb_data", i), wb_data, tbl[i].e_wbdata);
      chk($sformatf("tbl%0d fault", i), {31'h0, fault}, {31'h0, tbl[i].e_fault});
      chk($sformatf("tbl%0d fault_addr", i), fault_addr, tbl[i].e_faddr);
      chk($sformatf("tbl%0d store_count", i), {16'h0, store_count}, {16'h0, tbl[i].e_cnt});
    end

    // stall: store held in MEM for three cycles, then commits exactly once
    do_reset();
    drive(1'b1, 32'h240, 32'h5A, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    for (int c = 0; c < 3; c++) begin
      bubble(1'b1, 1'b0);
      #1;
      chk($sformatf("stall%0d dm_wren", c), {31'h0, dm_wren}, 32'h1);
      step();
      chk($sformatf("stall%0d wb_valid", c), {31'h0, wb_valid}, 32'h0);
      chk($sformatf("stall%0d store_count", c), {16'h0, store_count}, 32'h0);
    end
    bubble(1'b0, 1'b0);
    #1;
    chk("stall release dm_wren", {31'h0, dm_wren}, 32'h0);
    chk("stall release dm_address", {24'h0, dm_address}, 32'h90);
    step();
    chk("stall release wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("stall release store_count", {16'h0, store_count}, 32'h1);
    #1;
    chk("stall after dm_wren", {31'h0, dm_wren}, 32'h1);
    step();
    chk("stall once store_count", {16'h0, store_count}, 32'h1);
    chk("stall once mem", {24'h0, env_mem[8'h90]}, 32'h5A);

    // flush without and with stall
    for (int s = 0; s < 2; s++) begin
      base = store_count;
      drive(1'b1, 32'h240, 32'h66, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      step();
      bubble(s[0], 1'b1);
      #1;
      chk($sformatf("flush%0d dm_wren", s), {31'h0, dm_wren}, 32'h1);
      step();
      chk($sformatf("flush%0d wb_valid", s), {31'h0, wb_valid}, 32'h0);
      bubble(1'b0, 1'b0);
      #1;
      chk($sformatf("flush%0d dm_wren after", s), {31'h0, dm_wren}, 32'h1);
      step();
      chk($sformatf("flush%0d store_count", s), {16'h0, store_count}, {16'h0, base});
      chk($sformatf("flush%0d wb_valid after", s), {31'h0, wb_valid}, 32'h0);
    end

    // a flushed bad access must not be recorded
    drive(1'b1, 32'h242, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    bubble(1'b0, 1'b1);
    step();
    chk("flushed fault", {31'h0, fault}, 32'h0);

    // back-to-back store then load to the same byte
    drive(1'b1, 32'h100, 32'hC3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0);
    step();
    bubble(1'b0, 1'b0);
    step();
    chk("b2b load wb_data", wb_data, 32'hC3);
    chk("b2b load wb_rd", {27'h0, wb_rd}, 32'd12);

    // randomized run against the instruction-level model
    begin
      ins_t        ms;
      ins_t        nx;
      logic [7:0]  ref_mem [256];
      logic        e_wbv, e_wbrw, e_flt;
      logic [4:0]  e_wbrd;
      logic [31:0] e_wbdata, e_faddr;
      logic [15:0] e_cnt;
      logic        st, fl, acc, bad, wr;
      int          idx, op, r;
      logic [7:0]  rdata;

      do_reset();
      foreach (ref_mem[k]) ref_mem[k] = 8'h00;
      ms = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0};
      e_wbv = 0; e_wbrw = 0; e_wbrd = 0; e_wbdata = 0; e_flt = 0; e_faddr = 0; e_cnt = 0;

      for (int n = 0; n < 1500; n++) begin
        r = $urandom_range(0, 99);
        if (r < 80)      nx.alu = 32'($urandom_range(0, 15) * 4);
        else if (r < 88) nx.alu = 32'($urandom_range(0, 63)) | 32'h1;
        else if (r < 94) nx.alu = 32'h400 + 32'($urandom_range(0, 255) * 4);
        else             nx.alu = $urandom;
        op = $urandom_range(0, 9);
        nx.rd_en = (op <= 3) || (op == 9);
        nx.wr_en = (op >= 4 && op <= 6) || (op == 9);
        nx.rw    = !nx.wr_en || op == 9;
        nx.v     = ($urandom_range(0, 9) != 0);
        nx.sd    = $urandom;
        nx.rd    = 5'($urandom_range(0, 31));
        st = ($urandom_range(0, 4) == 0);
        fl = ($urandom_range(0, 9) == 0);
        drive(nx.v, nx.alu, nx.sd, nx.rd_en, nx.wr_en, nx.rw, nx.rd, st, fl);
        #1;

        idx = int'((ms.alu / 4) % 256);
        acc = ms.v && (ms.rd_en || ms.wr_en);
        bad = acc && ((ms.alu % 4) != 0 || ms.alu >= 32'd1024 || (ms.rd_en && ms.wr_en));
        wr  = ms.v && ms.wr_en && !bad && !st && !fl;
        chk("rand dm_wren", {31'h0, dm_wren}, {31'h0, !wr});
        chk("rand dm_address", {24'h0, dm_address}, 32'(idx));
        chk("rand dm_w_data", {24'h0, dm_w_data}, {24'h0, ms.sd[7:0]});

        rdata = ref_mem[idx];
        if (wr) begin
          ref_mem[idx] = ms.sd[7:0];
          e_cnt = e_cnt + 16'd1;
        end
        if (!st) begin
          e_wbv    = ms.v && !bad && !fl;
          e_wbrw   = e_wbv && ms.rw;
          e_wbrd   = ms.rd;
          e_wbdata = ms.rd_en ? {24'h0, rdata} : ms.alu;
        end else begin
          e_wbv  = 1'b0;
          e_wbrw = 1'b0;
        end
        if (bad && !st && !fl && !e_flt) begin
          e_flt   = 1'b1;
          e_faddr = ms.alu;
        end
        if (!st) ms = nx;
        if (fl) ms.v = 1'b0;

        @(posedge clk);
        #1;
        chk("rand wb_valid", {31'h0, wb_valid}, {31'h0, e_wbv});
        chk("rand wb_reg_write", {31'h0, wb_reg_write}, {31'h0, e_wbrw});
        chk("rand wb_rd", {27'h0, wb_rd}, {27'h0, e_wbrd});
        chk("rand wb_data", wb_data, e_wbdata);
        chk("rand fault", {31'h0, fault}, {31'h0, e_flt});
        chk("rand fault_addr", fault_addr, e_faddr);
        chk("rand store_count", {16'h0, store_count}, {16'h0, e_cnt});
      end
    end

    // counter wrap: 65535 commits reach the top value, one more wraps to zero
    do_reset();
    drive(1'b1, 32'h0, 32'h1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (65536) @(posedge clk);
    #1;
    chk("wrap top", {16'h0, store_count}, 32'h0000FFFF);
    step();
    chk("wrap zero", {16'h0, store_count}, 32'h0);

    // reset asserted mid-stall with a store in MEM
    drive(1'b1, 32'h3FC, 32'hAB, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h208, 32'h0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    step();
    chk("pre-reset stall dm_wren", {31'h0, dm_wren}, 32'h1);
    chk("pre-reset dm_address", {24'h0, dm_address}, 32'hFF);
    stall = 1'b0;
    #1;
    chk("pre-reset store dm_wren", {31'h0, dm_wren}, 32'h0);
    stall = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async reset");
    bubble(1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
